// File: rtl/iq_burst_source.sv
// iq_burst_source
// Transmit-side test source. Emits one offset-binary 24-bit I/Q sample per
// clock: a quadrature square wave whose envelope ramps linearly up to a
// programmable level, holds, ramps back down and optionally repeats after a
// gap. Midscale 24'h800000 represents zero.

module iq_burst_source #(
    parameter int unsigned PHASE_W   = 16,
    parameter int unsigned AMP_SHIFT = 15
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stop,
    input  logic [7:0]         Level,
    input  logic [PHASE_W-1:0] Frequency,
    input  logic [15:0]        BurstLength,
    input  logic [15:0]        GapLength,
    input  logic               Repeat,
    output logic               Busy,
    output logic               Valid,
    output logic [23:0]        Output_I,
    output logic [23:0]        Output_Q
);

    localparam logic [23:0] MIDSCALE = 24'h800000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD,
        S_RAMP_DOWN,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    // Envelope, phase and segment counter
    logic [7:0]         amp_q,   amp_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [15:0]        cnt_q,   cnt_d;

    // Burst parameters captured on an accepted Start
    logic [7:0]         level_l_q,  level_l_d;
    logic [PHASE_W-1:0] freq_l_q,   freq_l_d;
    logic [15:0]        burst_l_q,  burst_l_d;
    logic [15:0]        gap_l_q,    gap_l_d;
    logic               repeat_l_q, repeat_l_d;

    // Registered output stage
    logic               valid_q, valid_d;
    logic [23:0]        out_i_q, out_i_d;
    logic [23:0]        out_q_q, out_q_d;

    // Helper terms
    logic [15:0]        hold_last;
    logic [15:0]        gap_last;
    logic               amp_at_level;
    logic               amp_zero;
    logic               repeat_eff;
    logic [23:0]        mag;
    logic [1:0]         quad;

    // Segment end points; a zero length is treated as a single cycle
    always_comb begin
        hold_last    = (burst_l_q == 16'd0) ? 16'd0 : burst_l_q - 16'd1;
        gap_last     = (gap_l_q   == 16'd0) ? 16'd0 : gap_l_q   - 16'd1;
        amp_at_level = (amp_q == level_l_q);
        amp_zero     = (amp_q == 8'd0);
        // A Stop seen in the final ramp-down cycle must still suppress the gap
        repeat_eff   = repeat_l_q & ~Stop;
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Stop takes priority over the normal segment exits
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (Stop) begin
                    state_d = S_RAMP_DOWN;
                end else if (amp_at_level) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Stop || (cnt_q == hold_last)) begin
                    state_d = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (amp_zero) begin
                    state_d = repeat_eff ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (Stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == gap_last) begin
                    state_d = S_RAMP_UP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: Busy straight from the state register, next sample from
    // the current envelope and phase quadrant
    always_comb begin
        Busy    = (state_q != S_IDLE);
        valid_d = Busy;
        mag     = 24'(amp_q) << AMP_SHIFT;
        quad    = phase_q[PHASE_W-1 -: 2];
        out_i_d = MIDSCALE;
        out_q_d = MIDSCALE;
        if (state_q != S_IDLE) begin
            out_i_d = ((quad == 2'd0) || (quad == 2'd3)) ? MIDSCALE + mag : MIDSCALE - mag;
            out_q_d = ((quad == 2'd0) || (quad == 2'd1)) ? MIDSCALE + mag : MIDSCALE - mag;
        end
    end

    // Datapath next values: envelope, counter, phase and parameter capture
    always_comb begin
        amp_d      = amp_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        level_l_d  = level_l_q;
        freq_l_d   = freq_l_q;
        burst_l_d  = burst_l_q;
        gap_l_d    = gap_l_q;
        repeat_l_d = repeat_l_q;

        if (state_q == S_IDLE) begin
            amp_d   = 8'd0;
            cnt_d   = 16'd0;
            phase_d = '0;
            if (Start) begin
                level_l_d  = Level;
                freq_l_d   = Frequency;
                burst_l_d  = BurstLength;
                gap_l_d    = GapLength;
                repeat_l_d = Repeat;
            end
        end else begin
            phase_d = phase_q + freq_l_q;
            if (Stop) begin
                repeat_l_d = 1'b0;
            end
            case (state_q)
                S_RAMP_UP: begin
                    // On Stop the envelope freezes so ramp-down starts here
                    if (!Stop) begin
                        if (amp_at_level) begin
                            cnt_d = 16'd0;
                        end else begin
                            amp_d = amp_q + 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    cnt_d = cnt_q + 16'd1;
                end
                S_RAMP_DOWN: begin
                    if (amp_zero) begin
                        cnt_d = 16'd0;
                    end else begin
                        amp_d = amp_q - 8'd1;
                    end
                end
                S_GAP: begin
                    amp_d = 8'd0;
                    if (state_d == S_GAP) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = 16'd0;
                    end
                end
                default: begin
                    amp_d = 8'd0;
                end
            endcase
            if (state_d == S_IDLE) begin
                phase_d = '0;
                amp_d   = 8'd0;
                cnt_d   = 16'd0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            amp_q      <= 8'd0;
            cnt_q      <= 16'd0;
            phase_q    <= '0;
            level_l_q  <= 8'd0;
            freq_l_q   <= '0;
            burst_l_q  <= 16'd0;
            gap_l_q    <= 16'd0;
            repeat_l_q <= 1'b0;
            valid_q    <= 1'b0;
            out_i_q    <= MIDSCALE;
            out_q_q    <= MIDSCALE;
        end else begin
            amp_q      <= amp_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            level_l_q  <= level_l_d;
            freq_l_q   <= freq_l_d;
            burst_l_q  <= burst_l_d;
            gap_l_q    <= gap_l_d;
            repeat_l_q <= repeat_l_d;
            valid_q    <= valid_d;
            out_i_q    <= out_i_d;
            out_q_q    <= out_q_d;
        end
    end

    assign Valid    = valid_q;
    assign Output_I = out_i_q;
    assign Output_Q = out_q_q;

endmodule

// File: tb/tb_iq_burst_source.sv
// tb_iq_burst_source
// Directed and randomized bursts compared cycle by cycle against an envelope
// model built from the segment lengths (ramp, hold, ramp, gap).

module tb_iq_burst_source;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Stop;
    logic [7:0]  Level;
    logic [15:0] Frequency;
    logic [15:0] BurstLength;
    logic [15:0] GapLength;
    logic        Repeat;
    logic        Busy;
    logic        Valid;
    logic [23:0] Output_I;
    logic [23:0] Output_Q;

    int n_checks = 0;
    int n_errors = 0;
    int exp_amp[$];

    iq_burst_source #(
        .PHASE_W   (16),
        .AMP_SHIFT (15)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stop        (Stop),
        .Level       (Level),
        .Frequency   (Frequency),
        .BurstLength (BurstLength),
        .GapLength   (GapLength),
        .Repeat      (Repeat),
        .Busy        (Busy),
        .Valid       (Valid),
        .Output_I    (Output_I),
        .Output_Q    (Output_Q)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle envelope of one run: ramp 0..L, hold L, ramp L..0, gap 0s,
    // repeating when rep; a Stop at index stop_at ramps down from there
    task automatic build_model(input int L, input int BL, input int GL, input bit rep,
                               input int stop_at);
        int beff, geff, burst, period, p, a;
        beff   = (BL == 0) ? 1 : BL;
        geff   = (GL == 0) ? 1 : GL;
        burst  = 2 * L + 2 + beff;
        period = rep ? burst + geff : burst;
        exp_amp.delete();
        for (int k = 0; k < 4000; k++) begin
            if (!rep && k >= burst) break;
            p = k % period;
            if (p <= L)                a = p;
            else if (p < L + 1 + beff) a = L;
            else if (p < burst)        a = L - (p - (L + 1 + beff));
            else                       a = 0;
            exp_amp.push_back(a);
            if (k == stop_at) begin
                if (p < L + 1 + beff) begin
                    for (int x = a; x >= 0; x--) exp_amp.push_back(x);
                end else if (p < burst) begin
                    for (int x = a - 1; x >= 0; x--) exp_amp.push_back(x);
                end
                break;
            end
        end
    endtask

    function automatic logic [23:0] exp_sample(input int a, input logic [15:0] ph, input bit is_q);
        logic [23:0] m;
        logic [1:0]  q;
        bit          pos;
        m   = 24'(a) * 24'h008000;
        q   = ph[15:14];
        pos = is_q ? (q < 2'd2) : ((q == 2'd0) || (q == 2'd3));
        return pos ? 24'h800000 + m : 24'h800000 - m;
    endfunction

    // Starts a run at the current falling edge and checks every cycle until idle
    task automatic run_burst(input string name, input int L, input logic [15:0] F,
                             input int BL, input int GL, input bit rep, input int stop_at,
                             input bit stop_with_start, input int restart_at,
                             output int busy_cycles);
        int          len, j;
        logic [15:0] ph;
        logic [23:0] ei, eq;
        build_model(L, BL, GL, rep, stop_at);
        len         = exp_amp.size();
        Level       = 8'(L);
        Frequency   = F;
        BurstLength = 16'(BL);
        GapLength   = 16'(GL);
        Repeat      = rep;
        Start       = 1'b1;
        Stop        = stop_with_start;
        busy_cycles = 0;
        for (int t = 1; t <= len + 2; t++) begin
            @(negedge Clk);
            Start = 1'b0;
            Stop  = 1'b0;
            if (Busy) busy_cycles++;
            check($sformatf("%s busy[%0d]", name, t), Busy, (t - 1 < len));
            j = t - 2;
            check($sformatf("%s valid[%0d]", name, t), Valid, (j >= 0 && j < len));
            if (j >= 0 && j < len) begin
                ph = 16'(j * int'(F));
                ei = exp_sample(exp_amp[j], ph, 1'b0);
                eq = exp_sample(exp_amp[j], ph, 1'b1);
            end else begin
                ei = 24'h800000;
                eq = 24'h800000;
            end
            check($sformatf("%s i[%0d]", name, t), Output_I, ei);
            check($sformatf("%s q[%0d]", name, t), Output_Q, eq);
            if (t == stop_at + 1) Stop = 1'b1;
            if (t == restart_at + 1) begin
                Start       = 1'b1;
                Level       = 8'(L + 3);
                Frequency   = F ^ 16'h1234;
                BurstLength = 16'(BL + 5);
                GapLength   = 16'(GL + 2);
                Repeat      = ~rep;
            end
        end
        Start = 1'b0;
        Stop  = 1'b0;
        check($sformatf("%s busy_len", name), busy_cycles, len);
    endtask

    initial begin
        int bc, L, BL, GL, beff, geff, burst, period, stop_at;
        bit rep;
        logic [15:0] F;

        Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Level = '0; Frequency = '0;
        BurstLength = '0; GapLength = '0; Repeat = 1'b0;
        #2;
        check("reset busy", Busy, 1'b0);
        check("reset valid", Valid, 1'b0);
        check("reset i", Output_I, 24'h800000);
        check("reset q", Output_Q, 24'h800000);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        run_burst("basic", 4, 16'h4000, 3, 0, 1'b0, -1, 1'b0, -1, bc);
        check("basic busy13", bc, 13);
        run_burst("full", 255, 16'h0000, 10, 0, 1'b0, -1, 1'b0, -1, bc);
        check("full busy522", bc, 522);
        run_burst("repeat", 2, 16'h4000, 2, 5, 1'b1, 36, 1'b0, -1, bc);
        check("repeat busy37", bc, 37);
        run_burst("stop_hold", 8, 16'h1357, 20, 3, 1'b1, 10, 1'b0, -1, bc);
        check("stop_hold busy20", bc, 20);
        run_burst("restart", 5, 16'h2000, 4, 0, 1'b0, -1, 1'b0, 7, bc);
        run_burst("start_stop", 3, 16'h4000, 2, 0, 1'b0, -1, 1'b1, -1, bc);
        run_burst("zero", 0, 16'h8000, 0, 0, 1'b1, 7, 1'b0, -1, bc);
        run_burst("stop_ramp_up", 10, 16'h0C00, 3, 0, 1'b0, 4, 1'b0, -1, bc);
        run_burst("stop_ramp_dn", 5, 16'h3000, 2, 4, 1'b1, 11, 1'b0, -1, bc);

        // Asynchronous reset in the middle of HOLD
        Level = 8'd6; Frequency = 16'h2000; BurstLength = 16'd10; GapLength = 16'd0;
        Repeat = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        check("pre_reset busy", Busy, 1'b1);
        check("pre_reset valid", Valid, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("async reset busy", Busy, 1'b0);
        check("async reset valid", Valid, 1'b0);
        check("async reset i", Output_I, 24'h800000);
        check("async reset q", Output_Q, 24'h800000);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_reset busy", Busy, 1'b0);
        run_burst("after_reset", 3, 16'h4000, 2, 0, 1'b0, -1, 1'b0, -1, bc);

        for (int n = 0; n < 25; n++) begin
            L      = int'($urandom_range(0, 24));
            F      = 16'($urandom);
            BL     = int'($urandom_range(0, 6));
            GL     = int'($urandom_range(0, 5));
            rep    = 1'($urandom_range(0, 1));
            beff   = (BL == 0) ? 1 : BL;
            geff   = (GL == 0) ? 1 : GL;
            burst  = 2 * L + 2 + beff;
            period = burst + geff;
            if (rep) begin
                stop_at = int'($urandom_range(0, 3 * period - 1));
            end else if ($urandom_range(0, 1) == 1) begin
                stop_at = int'($urandom_range(0, burst - 1));
            end else begin
                stop_at = -1;
            end
            run_burst($sformatf("rnd%0d", n), L, F, BL, GL, rep, stop_at, 1'b0, -1, bc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iq_burst_source.md
Name: iq_burst_source

Overview:
- Transmit-side test source producing one complex I/Q sample per clock.
- Output format matches the receive-side energy path: 24-bit offset-binary I/Q, with 24'h800000 as zero.
- Generates constant-envelope quadrature square-wave bursts with linear amplitude ramps, programmable level, frequency, burst length, gap and repeat.
- Drives the energy measurement chain in loop-back and bench testing.

Parameters:
- PHASE_W, 16, phase accumulator width; quadrant taken from the top 2 bits.
- AMP_SHIFT, 15, left shift applied to the 8-bit amplitude before adding to or subtracting from midscale.

Ports:
- Clk  input  1  sample clock (780 kHz in system).
- Reset  input  1  asynchronous, active-high.
- Start  input  1  single-cycle pulse; begins a burst sequence when idle.
- Stop  input  1  single-cycle pulse; requests orderly shutdown.
- Level  input  8  target amplitude; latched on accepted Start.
- Frequency  input  PHASE_W  phase increment per clock; latched on Start.
- BurstLength  input  16  HOLD duration in cycles; latched on Start.
- GapLength  input  16  GAP duration in cycles; latched on Start.
- Repeat  input  1  loop bursts until Stop; latched on Start.
- Busy  output  1  state is not IDLE (combinational from state register).
- Valid  output  1  registered Busy, aligned with Output_I/Output_Q.
- Output_I  output  24  offset-binary in-phase sample.
- Output_Q  output  24  offset-binary quadrature sample.

Behaviour:
- Reset (asynchronous): state IDLE; Amp=0; Phase=0; all latched inputs 0; Busy=0; Valid=0; Output_I=Output_Q=24'h800000.
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, GAP.
- IDLE:
  - Amp=0, Phase=0.
  - Start → latch Level/Frequency/BurstLength/GapLength/Repeat; go to RAMP_UP.
  - Stop in IDLE is ignored.
- RAMP_UP: if Amp==Level_l → HOLD, Cnt=0; else Amp+=1. Level=0 gives one RAMP_UP cycle at Amp 0.
- HOLD:
  - Cnt+=1; when Cnt==BurstLength_l-1 → RAMP_DOWN.
  - BurstLength=0 behaves as 1.
- RAMP_DOWN:
  - If Amp==0: go to GAP if Repeat_l, else IDLE. Set Cnt=0.
  - Otherwise Amp-=1.
- GAP:
  - Amp stays 0.
  - GapLength=0 → RAMP_UP on the next edge.
  - Otherwise Cnt+=1 each cycle; when Cnt==GapLength_l-1 → RAMP_UP.
  - Parameters are not relatched between bursts.
- Stop (any non-IDLE state):
  - Clears Repeat_l.
  - RAMP_UP/HOLD → RAMP_DOWN next edge, ramping down from the current Amp.
  - RAMP_DOWN: continues and ends in IDLE.
  - GAP → IDLE.
- Start and Stop in the same cycle while IDLE: Start accepted, Stop ignored.
- Start while Busy is ignored; no parameter change.
- Phase: Phase+=Frequency_l every non-IDLE clock; wraps modulo 2^PHASE_W; reset to 0 on entering IDLE.
- Output (registered, one-cycle latency from the state/Amp/Phase of the same cycle): let M=Amp<<AMP_SHIFT, q=Phase[MSB:MSB-1].
  - q=0: I=+M, Q=+M
  - q=1: I=−M, Q=+M
  - q=2: I=−M, Q=−M
  - q=3: I=+M, Q=−M
  - Output = 24'h800000 ± M.
  - Amp=255 gives 24'hFF8000 or 24'h008000; no overflow is possible.
  - In IDLE, both outputs register 24'h800000.
- Busy duration of a single burst: 2·Level+2+max(BurstLength,1) cycles.
- Valid is Busy delayed one cycle.
- Reset mid-burst forces the reset values immediately; no ramp-down.

Test Plan:
- Level=4, Frequency=16'h4000, BurstLength=3, Repeat=0, Start pulse:
  - Busy high exactly 13 cycles.
  - Valid-aligned |I−8'h800000|>>15 sequence: 0,1,2,3,4,4,4,4,4,3,2,1,0.
  - I signs rotate +,−,−,+ and Q signs +,+,−,− per sample.
  - Ends IDLE with outputs 24'h800000.
- Level=255, Frequency=0, BurstLength=10:
  - HOLD outputs I=Q=24'hFF8000, no wrap.
  - Total Busy 522 cycles.
- Repeat=1, Level=2, BurstLength=2, GapLength=5:
  - Busy stays high.
  - Pattern of 8 active cycles then 5 cycles at 24'h800000 repeats; verify three periods.
  - Stop during GAP → IDLE next edge.
- Stop asserted in the 2nd HOLD cycle (Level=8):
  - Next edge enters RAMP_DOWN.
  - Amplitude descends 8..0, then IDLE despite Repeat=1.
- Start re-pulsed mid-burst with different Level: ignored, original burst unaltered.
- Reset pulsed during HOLD: all outputs at reset values without waiting for a clock edge.
- After Reset release, a fresh Start produces a correct burst.
